// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between WB-stage CSRs and the TLB array.
module tlb_op_ctrl #(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = $clog2(TLBNUM),
    parameter int PTW        = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [4:0]            req_inv_op,
    input  logic [9:0]            req_inv_asid,
    input  logic [18:0]           req_inv_va,
    input  logic [TLBNUMSIZE-1:0] csr_idx,
    input  logic [5:0]            csr_ps,
    input  logic                  csr_ne,
    input  logic [18:0]           csr_vppn,
    input  logic [9:0]            csr_asid,
    input  logic [PTW-1:0]        csr_elo0,
    input  logic [PTW-1:0]        csr_elo1,
    input  logic                  csr_g0,
    input  logic                  csr_g1,
    input  logic                  in_tlbr,
    output logic                  s_sel,
    output logic [18:0]           s_vppn,
    output logic [9:0]            s_asid,
    output logic                  s_odd,
    input  logic [TLBNUMSIZE-1:0] s_index,
    input  logic                  s_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    input  logic [5:0]            r_ps,
    input  logic [9:0]            r_asid,
    input  logic                  r_ne,
    input  logic                  r_g,
    input  logic [18:0]           r_vppn,
    input  logic [PTW-1:0]        r_phytran0,
    input  logic [PTW-1:0]        r_phytran1,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic [5:0]            w_ps,
    output logic                  w_ne,
    output logic [9:0]            w_asid,
    output logic [18:0]           w_vppn,
    output logic                  w_g,
    output logic [PTW-1:0]        w_phytran0,
    output logic [PTW-1:0]        w_phytran1,
    output logic                  fe,
    output logic [2:0]            f_op,
    output logic [9:0]            f_asid,
    output logic [18:0]           f_va,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_exc,
    output logic                  idx_we,
    output logic [TLBNUMSIZE-1:0] idx_out,
    output logic                  ne_we,
    output logic                  ne_out,
    output logic                  ent_we,
    output logic [5:0]            ps_out,
    output logic [18:0]           vppn_out,
    output logic [9:0]            asid_out,
    output logic [PTW-1:0]        elo0_out,
    output logic [PTW-1:0]        elo1_out,
    output logic                  g_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

    state_e state_q, state_d;
    logic [2:0]            op_q, inv_op_q;
    logic [9:0]            inv_asid_q, casid_q, oasid_q;
    logic [18:0]           inv_va_q, cvppn_q, ovppn_q;
    logic [TLBNUMSIZE-1:0] cidx_q, fill_q, cnt_q, oidx_q;
    logic [5:0]            cps_q, ops_q;
    logic [PTW-1:0]        celo0_q, celo1_q, oelo0_q, oelo1_q;
    logic                  cne_q, cg0_q, cg1_q, tlbr_q, exc_q, one_q, og_q;
    logic                  issue, do_wr, hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            {op_q, inv_op_q, inv_asid_q, inv_va_q, cidx_q, cps_q, cne_q, cvppn_q, casid_q} <= '0;
            {celo0_q, celo1_q, cg0_q, cg1_q, tlbr_q, fill_q, cnt_q, exc_q} <= '0;
            {oidx_q, one_q, ops_q, ovppn_q, oasid_q, oelo0_q, oelo1_q, og_q} <= '0;
        end else begin
            state_q <= state_d;
            // wraps at TLBNUM-1 so non-power-of-two table sizes stay in range
            cnt_q   <= (cnt_q == TLBNUMSIZE'(TLBNUM - 1)) ? '0 : cnt_q + TLBNUMSIZE'(1);
            if (state_q == IDLE && req_valid) begin
                op_q       <= req_op;
                inv_op_q   <= req_inv_op[2:0];
                inv_asid_q <= req_inv_asid;
                inv_va_q   <= req_inv_va;
                cidx_q     <= csr_idx;
                cps_q      <= csr_ps;
                cne_q      <= csr_ne;
                cvppn_q    <= csr_vppn;
                casid_q    <= csr_asid;
                celo0_q    <= csr_elo0;
                celo1_q    <= csr_elo1;
                cg0_q      <= csr_g0;
                cg1_q      <= csr_g1;
                tlbr_q     <= in_tlbr;
                fill_q     <= cnt_q;
                exc_q      <= (req_op > OP_INV) || (req_op == OP_INV && req_inv_op > 5'd6);
            end
            if (state_q == ISSUE && op_q == OP_SRCH) begin
                oidx_q <= s_index;
                one_q  <= s_ne;
            end
            if (state_q == ISSUE && op_q == OP_RD) begin
                one_q   <= r_ne;
                ops_q   <= r_ps;
                ovppn_q <= r_vppn;
                oasid_q <= r_asid;
                oelo0_q <= r_phytran0;
                oelo1_q <= r_phytran1;
                og_q    <= r_g;
            end
        end
    end

    always_comb begin
        issue      = state_q == ISSUE;
        do_wr      = issue && (op_q == OP_WR || op_q == OP_FILL);
        hs         = state_q == RESP && resp_ready && !exc_q && !reset;
        state_d    = state_q == IDLE  ? (req_valid ? ISSUE : IDLE) :
                     state_q == ISSUE ? RESP :
                     state_q == RESP  ? (resp_ready ? IDLE : RESP) : IDLE;
        req_ready  = state_q == IDLE;
        s_sel      = issue && op_q == OP_SRCH;
        s_vppn     = s_sel ? cvppn_q : '0;
        s_asid     = s_sel ? casid_q : '0;
        s_odd      = 1'b0;
        r_index    = (issue && op_q == OP_RD) ? cidx_q : '0;
        we         = do_wr;
        w_index    = !do_wr ? '0 : (op_q == OP_FILL ? fill_q : cidx_q);
        w_ps       = do_wr ? cps_q : '0;
        w_ne       = do_wr && !tlbr_q && cne_q;
        w_asid     = do_wr ? casid_q : '0;
        w_vppn     = do_wr ? cvppn_q : '0;
        w_g        = do_wr && cg0_q && cg1_q;
        w_phytran0 = do_wr ? celo0_q : '0;
        w_phytran1 = do_wr ? celo1_q : '0;
        fe         = issue && op_q == OP_INV && !exc_q;
        f_op       = fe ? inv_op_q : '0;
        f_asid     = fe ? inv_asid_q : '0;
        f_va       = fe ? inv_va_q : '0;
        resp_valid = state_q == RESP;
        resp_exc   = resp_valid && exc_q;
        idx_we     = hs && op_q == OP_SRCH && !one_q;
        ne_we      = hs && (op_q == OP_SRCH || op_q == OP_RD);
        ent_we     = hs && op_q == OP_RD;
        idx_out    = oidx_q;
        ne_out     = one_q;
        ps_out     = ops_q;
        vppn_out   = ovppn_q;
        asid_out   = oasid_q;
        elo0_out   = oelo0_q;
        elo1_out   = oelo1_q;
        g_out      = og_q;
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: bench with a behavioural TLB and transaction model checking tlb_op_ctrl every cycle.
module tb_tlb_op_ctrl;
    localparam int N = 16, IW = 4, PTW = 26;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic req_valid = 0, req_ready, resp_valid, resp_ready = 0, resp_exc;
    logic [2:0] req_op = 0;
    logic [4:0] req_inv_op = 0;
    logic [9:0] req_inv_asid = 0, csr_asid = 0, s_asid, r_asid, w_asid, f_asid, asid_out;
    logic [18:0] req_inv_va = 0, csr_vppn = 0, s_vppn, r_vppn, w_vppn, f_va, vppn_out;
    logic [IW-1:0] csr_idx = 0, s_index, r_index, w_index, idx_out;
    logic [5:0] csr_ps = 0, r_ps, w_ps, ps_out;
    logic csr_ne = 0, csr_g0 = 0, csr_g1 = 0, in_tlbr = 0;
    logic [PTW-1:0] csr_elo0 = 0, csr_elo1 = 0, r_phytran0, r_phytran1, w_phytran0, w_phytran1, elo0_out, elo1_out;
    logic s_sel, s_odd, s_ne, r_ne, r_g, we, w_ne, w_g, fe, idx_we, ne_we, ne_out, ent_we, g_out;
    logic [2:0] f_op;

    tlb_op_ctrl #(.TLBNUM(N), .TLBNUMSIZE(IW), .PTW(PTW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
        .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn), .csr_asid(csr_asid),
        .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_g0(csr_g0), .csr_g1(csr_g1), .in_tlbr(in_tlbr),
        .s_sel(s_sel), .s_vppn(s_vppn), .s_asid(s_asid), .s_odd(s_odd), .s_index(s_index), .s_ne(s_ne),
        .r_index(r_index), .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g), .r_vppn(r_vppn),
        .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
        .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid), .w_vppn(w_vppn), .w_g(w_g),
        .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
        .fe(fe), .f_op(f_op), .f_asid(f_asid), .f_va(f_va),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_exc(resp_exc),
        .idx_we(idx_we), .idx_out(idx_out), .ne_we(ne_we), .ne_out(ne_out), .ent_we(ent_we),
        .ps_out(ps_out), .vppn_out(vppn_out), .asid_out(asid_out), .elo0_out(elo0_out), .elo1_out(elo1_out),
        .g_out(g_out)
    );

    typedef struct packed {
        logic e; logic [5:0] ps; logic [18:0] vppn; logic [9:0] asid; logic g; logic [PTW-1:0] p0; logic [PTW-1:0] p1;
    } ent_t;
    ent_t tlb [N];
    logic tlb_clr = 1'b1;

    function automatic int find(input logic [18:0] v, input logic [9:0] a);
        for (int i = 0; i < N; i++)
            if (tlb[i].e && tlb[i].vppn == v && (tlb[i].g || tlb[i].asid == a)) return i;
        return -1;
    endfunction

    function automatic logic inv_hit(input logic [2:0] op, input logic [9:0] a, input logic [18:0] v, input ent_t t);
        case (op)
            3'd0, 3'd1: return 1'b1;
            3'd2: return t.g;
            3'd3: return !t.g;
            3'd4: return !t.g && t.asid == a;
            3'd5: return !t.g && t.asid == a && t.vppn == v;
            3'd6: return (t.g || t.asid == a) && t.vppn == v;
            default: return 1'b0;
        endcase
    endfunction

    int hit_i;
    ent_t rd;
    always_comb begin
        hit_i      = find(s_vppn, s_asid);
        s_index    = hit_i < 0 ? '0 : IW'(hit_i);
        s_ne       = hit_i < 0;
        rd         = tlb[r_index].e ? tlb[r_index] : '0;
        r_ne       = !rd.e;
        r_ps       = rd.ps;
        r_vppn     = rd.vppn;
        r_asid     = rd.asid;
        r_g        = rd.g;
        r_phytran0 = rd.p0;
        r_phytran1 = rd.p1;
    end

    always @(posedge clk) begin
        if (tlb_clr) for (int i = 0; i < N; i++) tlb[i] <= '0;
        else begin
            if (we) tlb[w_index] <= '{e: !w_ne, ps: w_ps, vppn: w_vppn, asid: w_asid, g: w_g, p0: w_phytran0, p1: w_phytran1};
            if (fe) for (int i = 0; i < N; i++) if (inv_hit(f_op, f_asid, f_va, tlb[i])) tlb[i].e <= 1'b0;
        end
    end

    // Transaction model: accept, one issue cycle, then response until handshake.
    int cyc = 0, m_age = 0;
    logic m_busy = 0, m_exc = 0, m_hit = 0;
    logic [2:0] m_op = 0, m_fop = 0;
    logic [IW-1:0] m_sidx = 0, m_widx = 0, m_ridx = 0;
    logic [9:0] m_fasid = 0, m_sasid = 0;
    logic [18:0] m_fva = 0, m_svppn = 0;
    ent_t m_rd = '0, m_w = '0;

    always @(posedge clk) begin
        if (reset) begin
            cyc <= 0; m_busy <= 0; m_age <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy && req_valid) begin
                m_busy  <= 1; m_age <= 1; m_op <= req_op;
                m_exc   <= req_op > 3'd4 || (req_op == 3'd4 && req_inv_op > 5'd6);
                m_hit   <= find(csr_vppn, csr_asid) >= 0;
                m_sidx  <= IW'(find(csr_vppn, csr_asid));
                m_svppn <= csr_vppn; m_sasid <= csr_asid; m_ridx <= csr_idx;
                m_rd    <= tlb[csr_idx].e ? tlb[csr_idx] : '0;
                m_w     <= '{e: in_tlbr | !csr_ne, ps: csr_ps, vppn: csr_vppn, asid: csr_asid, g: csr_g0 & csr_g1, p0: csr_elo0, p1: csr_elo1};
                m_widx  <= req_op == 3'd3 ? IW'(cyc % N) : csr_idx;
                m_fop   <= req_inv_op[2:0]; m_fasid <= req_inv_asid; m_fva <= req_inv_va;
            end else if (m_busy && m_age == 1) m_age <= 2;
            else if (m_busy && resp_ready) m_busy <= 0;
        end
    end

    int checks = 0, errors = 0, n_strb = 0, lat = 0;
    logic [IW-1:0] cap_idx = 0, cap_widx = 0;
    logic cap_ne = 0, cap_wne = 0, cap_exc = 0;
    logic [2:0] cap_fop = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic iss, rsp, hs;
        iss = m_busy && m_age == 1;
        rsp = m_busy && m_age >= 2;
        hs  = rsp && resp_ready && !reset && !m_exc;
        chk("req_ready", req_ready, !m_busy);
        chk("resp_valid", resp_valid, rsp);
        chk("resp_exc", resp_exc, rsp && m_exc);
        chk("s_sel", s_sel, iss && m_op == 3'd0);
        if (s_sel) begin chk("s_vppn", s_vppn, m_svppn); chk("s_asid", s_asid, m_sasid); chk("s_odd", s_odd, 0); end
        if (iss && m_op == 3'd1) chk("r_index", r_index, m_ridx);
        chk("we", we, iss && (m_op == 3'd2 || m_op == 3'd3));
        if (we) begin
            chk("w_index", w_index, m_widx); chk("w_ne", w_ne, !m_w.e); chk("w_g", w_g, m_w.g);
            chk("w_ps", w_ps, m_w.ps); chk("w_vppn", w_vppn, m_w.vppn); chk("w_asid", w_asid, m_w.asid);
            chk("w_pt0", w_phytran0, m_w.p0); chk("w_pt1", w_phytran1, m_w.p1);
        end
        chk("fe", fe, iss && m_op == 3'd4 && !m_exc);
        if (fe) begin chk("f_op", f_op, m_fop); chk("f_asid", f_asid, m_fasid); chk("f_va", f_va, m_fva); end
        chk("idx_we", idx_we, hs && m_op == 3'd0 && m_hit);
        chk("ne_we", ne_we, hs && (m_op == 3'd0 || m_op == 3'd1));
        chk("ent_we", ent_we, hs && m_op == 3'd1);
        if (idx_we) chk("idx_out", idx_out, m_sidx);
        if (ne_we) chk("ne_out", ne_out, m_op == 3'd0 ? !m_hit : !m_rd.e);
        if (ent_we) begin
            chk("ps_out", ps_out, m_rd.ps); chk("vppn_out", vppn_out, m_rd.vppn); chk("asid_out", asid_out, m_rd.asid);
            chk("elo0_out", elo0_out, m_rd.p0); chk("elo1_out", elo1_out, m_rd.p1); chk("g_out", g_out, m_rd.g);
        end
        if (we) begin cap_widx = w_index; cap_wne = w_ne; end
        if (idx_we) cap_idx = idx_out;
        if (ne_we) cap_ne = ne_out;
        if (fe) cap_fop = f_op;
        if (resp_exc) cap_exc = 1'b1;
        n_strb += int'(idx_we | ne_we | ent_we | we | fe);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic txn(input logic [2:0] op, input int hold, input logic poke);
        int n;
        req_op = op; req_valid = 1; step(); req_valid = 0;
        n = 0;
        while (!resp_valid && n < 8) begin step(); n++; end
        chk("resp_arrives", resp_valid, 1);
        lat = n;
        for (int i = 0; i < hold; i++) begin req_valid = poke; step(); end
        req_valid = 0; resp_ready = 1; step(); resp_ready = 0;
    endtask

    task automatic set_csr(input logic [IW-1:0] idx, input logic [18:0] v, input logic [9:0] a, input logic ne,
                           input logic g0, input logic g1, input logic tl);
        csr_idx = idx; csr_vppn = v; csr_asid = a; csr_ne = ne; csr_g0 = g0; csr_g1 = g1; in_tlbr = tl;
    endtask

    task automatic fill_after(input int k);
        reset = 1; step(); reset = 0;
        repeat (k) step();
        txn(3'd3, 0, 0);
    endtask

    initial begin
        int s0;
        step(); step();
        tlb_clr = 0; reset = 0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_idx_out", idx_out, 0);
        csr_ps = 6'd12; csr_elo0 = 26'h1234567; csr_elo1 = 26'h0FEDCBA;
        set_csr(4'd5, 19'h12345, 10'h3, 0, 0, 0, 0);
        txn(3'd2, 0, 0);
        chk("wr5_index", cap_widx, 5);
        txn(3'd0, 0, 0);
        chk("srch_latency", lat, 1);
        chk("srch_hit_idx", cap_idx, 5);
        chk("srch_hit_ne", cap_ne, 0);
        set_csr(4'd0, 19'h11111, 10'h3, 0, 0, 0, 0);
        txn(3'd0, 0, 0);
        chk("srch_miss_ne", cap_ne, 1);
        cap_ne = 0;
        set_csr(4'd0, 19'h12345, 10'h4, 0, 0, 0, 0);
        txn(3'd0, 0, 0);
        chk("srch_asid_miss_ne", cap_ne, 1);
        csr_ps = 6'd21; csr_elo0 = 26'h2AAAAAA; csr_elo1 = 26'h1555555;
        set_csr(4'd3, 19'h0ABCD, 10'h7, 1, 1, 0, 1);
        txn(3'd2, 0, 0);
        chk("wr3_index", cap_widx, 3);
        chk("wr3_ne", cap_wne, 0);
        cap_ne = 1;
        txn(3'd1, 0, 0);
        chk("rd3_ne", cap_ne, 0);
        chk("rd3_vppn", vppn_out, 19'h0ABCD);
        chk("rd3_ps", ps_out, 21);
        chk("rd3_g", g_out, 0);
        csr_idx = 4'd9;
        txn(3'd1, 0, 0);
        chk("rd9_invalid_ne", cap_ne, 1);
        chk("rd9_invalid_vppn", vppn_out, 0);
        req_inv_op = 5'd5; req_inv_asid = 10'h3; req_inv_va = 19'h12345;
        txn(3'd4, 0, 0);
        chk("inv5_op", cap_fop, 5);
        set_csr(4'd0, 19'h12345, 10'h3, 0, 0, 0, 0);
        cap_ne = 0;
        txn(3'd0, 0, 0);
        chk("srch_after_inv", cap_ne, 1);
        s0 = n_strb; cap_exc = 0;
        req_inv_op = 5'd9;
        txn(3'd4, 0, 0);
        chk("inv9_exc", cap_exc, 1);
        chk("inv9_no_strobe", n_strb - s0, 0);
        s0 = n_strb; cap_exc = 0;
        txn(3'd7, 0, 0);
        chk("illegal_op_exc", cap_exc, 1);
        chk("illegal_no_strobe", n_strb - s0, 0);
        csr_idx = 4'd3;
        txn(3'd1, 4, 1);
        csr_idx = 4'd9;
        fill_after(5);
        chk("fill_k5", cap_widx, 5);
        fill_after(15);
        chk("fill_k15", cap_widx, 15);
        fill_after(16);
        chk("fill_wrap", cap_widx, 0);
        csr_idx = 4'd3;
        req_op = 3'd1; req_valid = 1; step(); req_valid = 0;
        step();
        chk("rst_resp_pending", resp_valid, 1);
        reset = 1; resp_ready = 1; step(); reset = 0; resp_ready = 0;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ne_out", ne_out, 0);
        chk("rst_vppn_out", vppn_out, 0);
        chk("rst_ps_out", ps_out, 0);
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
